// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the SRAM arbiter: FSM state encoding, default
// geometry and timing constants, and the wait-counter width helper.
package sram_arbiter_pkg;

  localparam int DEF_AW      = 19;  // 512 KB byte-wide SRAM
  localparam int DEF_DW      = 8;
  localparam int DEF_RD_WAIT = 2;
  localparam int DEF_WR_WAIT = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD      = 2'd1,
    ST_WR      = 2'd2,
    ST_WR_HOLD = 2'd3
  } state_t;

  // Width able to hold the longest wait count, i.e. ceil(log2(max+1)).
  function automatic int cnt_width(input int rd_wait, input int wr_wait);
    int m;
    m = (rd_wait > wr_wait) ? rd_wait : wr_wait;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sram_arbiter_rr.sv
// Round-robin grant logic.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-channel request vector
//   advance    : the current grant is being taken; move priority past it
//   grant      : one-hot grant (all zero when nothing requests)
// Priority starts at the channel after the last granted one; channel 0 is
// highest after reset.
module rr_arbiter #(
  parameter int NCH = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] req,
  input  logic           advance,
  output logic [NCH-1:0] grant
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic [PW:0]   sum;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant   = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int i = 0; i < NCH; i++) begin
      // Rotate the search start to ptr, wrapping at NCH (not a power of two in general).
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(NCH)) sum = sum - (PW+1)'(NCH);
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        ptr_nxt    = (idx == PW'(NCH-1)) ? '0 : idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ptr <= '0;
    else if (advance) ptr <= ptr_nxt;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Multi-channel arbiter for an asynchronous byte-wide SRAM.
//   clk, power_on_reset_n        : clock, asynchronous active-low reset
//   req/we/addr/wdata            : per-channel request, direction, address, write data
//   ack                          : one-cycle completion pulse of the served channel
//   rdata                        : last read data, valid from the read's ack cycle
//   busy                         : a transaction is in flight
//   sram_addr/sram_data_o/_oe    : SRAM address, write data and pad output enable
//   sram_data_i                  : data returned from the SRAM pad
//   sram_we_n                    : registered, glitch-free write strobe
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int NCH     = 2,
  parameter int RD_WAIT = DEF_RD_WAIT,
  parameter int WR_WAIT = DEF_WR_WAIT
) (
  input  logic              clk,
  input  logic              power_on_reset_n,
  input  logic [NCH-1:0]    req,
  input  logic [NCH-1:0]    we,
  input  logic [NCH*AW-1:0] addr,
  input  logic [NCH*DW-1:0] wdata,
  output logic [NCH-1:0]    ack,
  output logic [DW-1:0]     rdata,
  output logic              busy,
  output logic [AW-1:0]     sram_addr,
  output logic [DW-1:0]     sram_data_o,
  output logic              sram_data_oe,
  input  logic [DW-1:0]     sram_data_i,
  output logic              sram_we_n
);

  localparam int            CW      = cnt_width(RD_WAIT, WR_WAIT);
  localparam logic [CW-1:0] RD_LAST = CW'(RD_WAIT - 1);
  localparam logic [CW-1:0] WR_LAST = CW'(WR_WAIT - 1);

  state_t         state;
  state_t         state_nxt;
  logic [CW-1:0]  wait_cnt;
  logic [NCH-1:0] gnt;
  logic [NCH-1:0] gnt_q;
  logic           take;
  logic           rd_last;
  logic           wr_last;
  logic [AW-1:0]  sel_addr;
  logic [DW-1:0]  sel_wdata;
  logic           sel_we;

  rr_arbiter #(.NCH(NCH)) u_rr (
    .clk     (clk),
    .rst_n   (power_on_reset_n),
    .req     (req),
    .advance (take),
    .grant   (gnt)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt[i]) begin
        sel_addr  = addr[i*AW +: AW];
        sel_wdata = wdata[i*DW +: DW];
        sel_we    = we[i];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge power_on_reset_n) begin
    if (!power_on_reset_n) state <= ST_IDLE;
    else                   state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (take) state_nxt = sel_we ? ST_WR : ST_RD;
      ST_RD:      if (rd_last) state_nxt = ST_IDLE;
      ST_WR:      if (wr_last) state_nxt = ST_WR_HOLD;
      ST_WR_HOLD: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Output decode. No grant in the ack cycle: the requester still holds req
  // there, and re-granting it would repeat the transaction just completed.
  always_comb begin
    take    = (state == ST_IDLE) && (|req) && !(|ack);
    rd_last = (state == ST_RD) && (wait_cnt == RD_LAST);
    wr_last = (state == ST_WR) && (wait_cnt == WR_LAST);
  end

  // Registered SRAM strobes and handshake
  always_ff @(posedge clk or negedge power_on_reset_n) begin
    if (!power_on_reset_n) begin
      wait_cnt     <= '0;
      gnt_q        <= '0;
      ack          <= '0;
      busy         <= 1'b0;
      rdata        <= '0;
      sram_addr    <= '0;
      sram_data_o  <= '0;
      sram_data_oe <= 1'b0;
      sram_we_n    <= 1'b1;
    end else begin
      ack <= '0;
      if (state == ST_RD || state == ST_WR) wait_cnt <= wait_cnt + 1'b1;
      case (state)
        ST_IDLE: begin
          if (take) begin
            wait_cnt     <= '0;
            gnt_q        <= gnt;
            busy         <= 1'b1;
            sram_addr    <= sel_addr;
            sram_data_oe <= sel_we;
            sram_we_n    <= !sel_we;
            if (sel_we) sram_data_o <= sel_wdata;
          end
        end
        ST_RD: begin
          if (rd_last) begin
            rdata <= sram_data_i;
            ack   <= gnt_q;
            busy  <= 1'b0;
          end
        end
        ST_WR: begin
          if (wr_last) sram_we_n <= 1'b1;
        end
        ST_WR_HOLD: begin
          // Address and data are still driven this cycle, giving hold time
          // after the rising edge of sram_we_n.
          ack          <= gnt_q;
          busy         <= 1'b0;
          sram_data_oe <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: default instance against a behavioural SRAM
// (35 write / 45 read delay), plus an NCH=4, RD_WAIT=3 instance.
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  localparam int AW = 19;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          power_on_reset_n = 1'b0;
  logic [1:0]    req = '0;
  logic [1:0]    we = '0;
  logic [2*AW-1:0] addr = '0;
  logic [2*DW-1:0] wdata = '0;
  logic [1:0]    ack;
  logic [DW-1:0] rdata;
  logic          busy;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_data_o;
  logic          sram_data_oe;
  logic [DW-1:0] sram_data_i;
  logic          sram_we_n;

  logic [3:0]      d4_req = '0;
  logic [3:0]      d4_we = '0;
  logic [4*AW-1:0] d4_addr = '0;
  logic [4*DW-1:0] d4_wdata = '0;
  logic [3:0]      d4_ack;
  logic [DW-1:0]   d4_rdata;
  logic            d4_busy;
  logic [AW-1:0]   d4_sram_addr;
  logic [DW-1:0]   d4_sram_data_o;
  logic            d4_sram_data_oe;
  logic [DW-1:0]   d4_sram_data_i;
  logic            d4_sram_we_n;

  sram_arbiter dut (
    .clk(clk), .power_on_reset_n(power_on_reset_n),
    .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .busy(busy),
    .sram_addr(sram_addr), .sram_data_o(sram_data_o), .sram_data_oe(sram_data_oe),
    .sram_data_i(sram_data_i), .sram_we_n(sram_we_n)
  );

  sram_arbiter #(.NCH(4), .RD_WAIT(3)) dut4 (
    .clk(clk), .power_on_reset_n(power_on_reset_n),
    .req(d4_req), .we(d4_we), .addr(d4_addr), .wdata(d4_wdata),
    .ack(d4_ack), .rdata(d4_rdata), .busy(d4_busy),
    .sram_addr(d4_sram_addr), .sram_data_o(d4_sram_data_o), .sram_data_oe(d4_sram_data_oe),
    .sram_data_i(d4_sram_data_i), .sram_we_n(d4_sram_we_n)
  );

  always #18 clk = ~clk;

  // Simple pattern memory for the 4-channel instance
  assign d4_sram_data_i = d4_sram_addr[7:0] ^ 8'h5A;

  // Behavioural SRAM
  logic [7:0] mem [0:(1<<19)-1];
  logic       mem_ev = 1'b0;
  realtime    t_fall = 0;

  always @(negedge sram_we_n) t_fall = $realtime;
  always @(posedge sram_we_n)
    if (power_on_reset_n && ($realtime - t_fall >= 35.0)) begin
      mem[sram_addr] = sram_data_o;
      mem_ev = ~mem_ev;
    end
  always begin
    @(sram_addr or mem_ev);
    sram_data_i = 8'hEE;
    #45;
    sram_data_i = mem[sram_addr];
  end

  int checks = 0;
  int failures = 0;
  int bptr = 0;

  typedef struct { int ch; bit rd; logic [7:0] data; } exp_t;
  exp_t sb [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Continuous protocol checks and scoreboard drain
  logic          we_low_q = 1'b0;
  logic [AW-1:0] addr_q = '0;
  always @(negedge clk) begin
    check("ack_onehot", {63'd0, $onehot0(ack)}, 64'd1);
    check("d4_ack_onehot", {63'd0, $onehot0(d4_ack)}, 64'd1);
    if (dut.state == ST_RD) check("oe_in_rd", {63'd0, sram_data_oe}, 64'd0);
    if (dut4.state == ST_RD) check("d4_oe_in_rd", {63'd0, d4_sram_data_oe}, 64'd0);
    if (!sram_we_n && we_low_q) check("addr_hold_we", {45'd0, sram_addr}, {45'd0, addr_q});
    we_low_q <= !sram_we_n;
    addr_q   <= sram_addr;
    if (|ack) begin
      if (sb.size() == 0) check("sb_unexpected_ack", {62'd0, ack}, 64'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_ch", {62'd0, ack}, 64'd1 << e.ch);
        if (e.rd) check("sb_rdata", {56'd0, rdata}, {56'd0, e.data});
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"},   {62'd0, ack}, 64'd0);
    check({tag, "_busy"},  {63'd0, busy}, 64'd0);
    check({tag, "_we_n"},  {63'd0, sram_we_n}, 64'd1);
    check({tag, "_oe"},    {63'd0, sram_data_oe}, 64'd0);
    check({tag, "_rdata"}, {56'd0, rdata}, 64'd0);
    check({tag, "_addr"},  {45'd0, sram_addr}, 64'd0);
    check({tag, "_dout"},  {56'd0, sram_data_o}, 64'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    power_on_reset_n = 1'b0;
    req = '0;
    d4_req = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs(tag);
    power_on_reset_n = 1'b1;
    bptr = 0;
    @(negedge clk);
  endtask

  // Single transaction on one channel with latency and strobe-width checks
  task automatic txn(input string tag, input int ch, input bit wr, input logic [AW-1:0] a,
                     input logic [7:0] d, input logic [7:0] exp_rd, input int exp_lat);
    int  n;
    int  wl;
    bit  got;
    sb.push_back('{ch: ch, rd: !wr, data: exp_rd});
    @(negedge clk);
    addr[ch*AW +: AW]  = a;
    wdata[ch*DW +: DW] = d;
    we[ch]  = wr;
    req[ch] = 1'b1;
    n = 0; wl = 0; got = 1'b0;
    while (!got && n < 50) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (!sram_we_n) wl++;
      if (ack[ch]) got = 1'b1;
    end
    req[ch] = 1'b0;
    check({tag, "_got_ack"}, {63'd0, got}, 64'd1);
    check({tag, "_latency"}, n, exp_lat);
    if (wr) check({tag, "_we_low_cycles"}, wl, 2);
    bptr = (ch + 1) % 2;
    repeat (2) @(negedge clk);
  endtask

  // Both channels read together; hold=1 keeps req high until n acks
  task automatic run_reads(input string tag, input int n, input bit hold);
    int got;
    int cyc;
    int c0;
    int c1;
    int ch;
    for (int k = 0; k < n; k++) begin
      ch = (bptr + k) % 2;
      sb.push_back('{ch: ch, rd: 1'b1, data: (ch == 1) ? 8'h3C : 8'h00});
    end
    bptr = ((bptr + n - 1) % 2 + 1) % 2;
    @(negedge clk);
    we   = 2'b00;
    addr = {19'h7FFFF, 19'h00000};
    req  = 2'b11;
    got = 0; cyc = 0; c0 = 0; c1 = 0;
    while (got < n && cyc < 50 * n) begin
      @(negedge clk);
      cyc++;
      if (ack[0]) begin c0++; got++; if (!hold) req[0] = 1'b0; end
      if (ack[1]) begin c1++; got++; if (!hold) req[1] = 1'b0; end
      if (got >= n) req = 2'b00;
    end
    req = 2'b00;
    check({tag, "_acks"}, got, n);
    check({tag, "_ch0_acks"}, c0, n / 2);
    check({tag, "_ch1_acks"}, c1, n / 2);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    int stable;
    bit got;
    for (int i = 0; i < (1 << 19); i++) mem[i] = 8'h00;

    // Reset state
    @(negedge clk);
    check_reset_outputs("por");
    check("por_d4_ack", {60'd0, d4_ack}, 64'd0);
    power_on_reset_n = 1'b1;
    @(negedge clk);

    // Write then read back on channel 0, write on channel 1
    txn("wr_ch0", 0, 1'b1, 19'h12345, 8'hA5, 8'h00, 4);
    txn("rd_ch0", 0, 1'b0, 19'h12345, 8'h00, 8'hA5, 3);
    txn("wr_ch1", 1, 1'b1, 19'h7FFFF, 8'h3C, 8'h00, 4);

    // Reset clears rdata and priority
    do_reset("rst1");

    // Simultaneous pair from reset: ch0 then ch1
    run_reads("pair1", 2, 1'b0);
    // After a lone ch0 grant the next pair starts with ch1
    txn("rd_ch0_b", 0, 1'b0, 19'h12345, 8'h00, 8'hA5, 3);
    run_reads("pair2", 2, 1'b0);

    // Continuous requests: strict alternation, 10/10
    run_reads("stream", 20, 1'b1);

    // Reset in the second cycle of sram_we_n low
    @(negedge clk);
    addr[0 +: AW] = 19'h00100;
    wdata[0 +: DW] = 8'h77;
    we[0]  = 1'b1;
    req[0] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #5;
    check("midwr_we_low_before", {63'd0, sram_we_n}, 64'd0);
    power_on_reset_n = 1'b0;
    #1;
    check("midwr_we_n", {63'd0, sram_we_n}, 64'd1);
    check("midwr_oe", {63'd0, sram_data_oe}, 64'd0);
    req = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("midwr");
    power_on_reset_n = 1'b1;
    bptr = 0;
    @(negedge clk);
    txn("after_abort_rd", 0, 1'b0, 19'h00100, 8'h00, 8'h00, 3);
    txn("after_abort_rd2", 1, 1'b0, 19'h12345, 8'h00, 8'hA5, 3);

    // Four-channel instance, RD_WAIT=3: read from channel 3
    @(negedge clk);
    d4_addr = '0;
    d4_addr[3*AW +: AW] = 19'h00001;
    d4_we  = 4'b0000;
    d4_req = 4'b1000;
    n = 0; stable = 0; got = 1'b0;
    while (!got && n < 30) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (d4_busy && d4_sram_addr == 19'h00001) stable++;
      if (|d4_ack) begin
        got = 1'b1;
        check("d4_ack_vec", {60'd0, d4_ack}, 64'h8);
        check("d4_rdata", {56'd0, d4_rdata}, 64'h5B);
      end
    end
    d4_req = '0;
    check("d4_got_ack", {63'd0, got}, 64'd1);
    check("d4_latency", n, 4);
    check("d4_addr_stable", stable, 3);

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter AW, default 19, SRAM address width (512 KB).
REQ-002 Parameter DW, default 8, SRAM data width.
REQ-003 Parameter NCH, default 2, number of requesting channels, legal range 1..8.
REQ-004 Parameter RD_WAIT, default 2, clk cycles the address is held before read data is sampled, minimum 1.
REQ-005 Parameter WR_WAIT, default 2, clk cycles sram_we_n is held low per write, minimum 1.
REQ-006 clk  input  1  system clock (28 MHz); all logic is on the rising edge.
REQ-007 power_on_reset_n  input  1  asynchronous active-low reset.
REQ-008 req  input  NCH  per-channel access request, held high until the matching ack.
REQ-009 we  input  NCH  per-channel direction: 1 = write, 0 = read.
REQ-010 addr  input  NCH*AW  per-channel address; channel i occupies bits [i*AW +: AW].
REQ-011 wdata  input  NCH*DW  per-channel write data; channel i occupies bits [i*DW +: DW].
REQ-012 ack  output  NCH  one-cycle completion pulse for the granted channel.
REQ-013 rdata  output  DW  read data, valid in the ack cycle of a read, held until the next read completes.
REQ-014 busy  output  1  high while any transaction is in flight.
REQ-015 sram_addr  output  AW  external SRAM address.
REQ-016 sram_data_o  output  DW  data driven to the SRAM.
REQ-017 sram_data_oe  output  1  tri-state enable for sram_data_o; the top level forms the inout pad.
REQ-018 sram_data_i  input  DW  data returned from the SRAM pad.
REQ-019 sram_we_n  output  1  SRAM write enable, active low.

Function
REQ-020 The FSM has four states: IDLE, RD, WR, WR_HOLD.
REQ-021 In IDLE with any req bit high, the block grants one channel round-robin, registers its addr, we and wdata, sets busy, and enters RD or WR on the next edge.
REQ-022 Round-robin search starts at the channel after the last granted one; after reset, channel 0 has highest priority.
REQ-023 With all channels continuously requesting, each channel is granted within NCH consecutive transactions.
REQ-024 RD: sram_addr is stable and sram_we_n = 1, sram_data_oe = 0 for RD_WAIT cycles; on the last cycle sram_data_i is registered into rdata, ack[g] pulses on the following cycle, and the FSM returns to IDLE.
REQ-025 WR: sram_addr, sram_data_o and sram_data_oe = 1 are driven, and sram_we_n = 0 for exactly WR_WAIT cycles; the FSM then enters WR_HOLD.
REQ-026 WR_HOLD (one cycle): sram_we_n = 1 while address and data stay driven, ack[g] pulses, then the FSM returns to IDLE with sram_data_oe = 0.
REQ-027 Latency from req sampled in IDLE to ack: RD_WAIT+1 cycles for a read and WR_WAIT+2 cycles for a write.
REQ-028 IDLE always lasts at least one cycle between transactions; there is no back-to-back streaming.
REQ-029 sram_we_n is glitch-free: it is a register output, and sram_addr never changes while sram_we_n = 0.
REQ-030 If req drops before ack, the transaction still completes and ack still pulses; the requester ignores it.
REQ-031 If req is still high in the cycle after ack, it is treated as a new request.
REQ-032 At most one ack bit is high in any cycle.
REQ-033 sram_addr keeps its last value in IDLE.

Reset
REQ-034 Assertion of power_on_reset_n, including mid-transaction, immediately forces: state = IDLE, sram_we_n = 1, sram_data_oe = 0, ack = 0, busy = 0, rdata = 0, sram_addr = 0, sram_data_o = 0, round-robin pointer = channel 0.
REQ-035 No ack is issued for a transaction aborted by reset.

Structure
REQ-036 A shared package sram_arbiter_pkg holds the state encoding and the default AW, DW, RD_WAIT and WR_WAIT constants.
REQ-037 Round-robin grant logic is a sub-module rr_arbiter, parameterised by NCH, with inputs req and advance and a one-hot grant output.
REQ-038 The wait counter is ceil(log2(max(RD_WAIT, WR_WAIT)+1)) bits wide.

Verification
REQ-039 Defaults, SRAM model with 35 ns write / 45 ns read delay, pre-loaded with 0x00; ch0 writes 0xA5 to 0x12345 -> sram_we_n low for exactly 2 cycles, ack[0] at cycle 4; ch0 then reads 0x12345 -> rdata = 0xA5 with ack[0] at cycle 3.
REQ-040 ch0 and ch1 raise read requests in the same cycle (addr 0x00000 and 0x7FFFF) -> ch0 is served first and ch1 second; a further simultaneous pair is served ch1 first.
REQ-041 Both channels hold req permanently for 20 transactions -> grants alternate strictly and ack counts are 10/10.
REQ-042 power_on_reset_n asserted during the second cycle of sram_we_n = 0 -> sram_we_n = 1 and sram_data_oe = 0 the same instant, no ack is issued, and the next request after release is served normally.
REQ-043 NCH = 4, RD_WAIT = 3: a read from channel 3 at address 0x00001 -> ack[3] at cycle 4, and sram_addr is stable for 3 cycles.
REQ-044 Assertions run throughout all scenarios: ack is one-hot or zero; sram_addr is stable while sram_we_n = 0; sram_data_oe = 0 whenever state = RD.
